// File: rtl/s_axi_read.sv
// rtl/s_axi_read.sv - AXI4-Lite read slave for the DFX sequencer register map
// Decodes a latched read address into bank0 registers or a bank1 slot-table field.
module s_axi_read #(
  parameter int ADDR_WIDTH           = 16,
  parameter int DATA_WIDTH           = 32,
  parameter int BANK1_INDEX_WIDTH    = 2,
  parameter int BANK1_SRC_ADDR_WIDTH = 32,
  parameter int BANK1_SRC_SIZE_WIDTH = 26,
  parameter int BANK1_DST_ADDR_WIDTH = 32,
  parameter int BANK1_DST_SIZE_WIDTH = 26,
  parameter int BANK1_STATUS_WIDTH   = 2,
  parameter int BANK1_PROFILE_WIDTH  = 32,
  parameter int BANK0_CONTROL_WIDTH  = 4,
  parameter int BANK0_STATUS_WIDTH   = 4,
  parameter int BANK0_CNT_WIDTH      = BANK1_INDEX_WIDTH
) (
  input  logic                            clk,
  input  logic                            reset,
  input  logic [ADDR_WIDTH-1:0]           S_AXI_ARADDR,
  input  logic                            S_AXI_ARVALID,
  output logic                            S_AXI_ARREADY,
  output logic [DATA_WIDTH-1:0]           S_AXI_RDATA,
  output logic [1:0]                      S_AXI_RRESP,
  output logic                            S_AXI_RVALID,
  input  logic                            S_AXI_RREADY,
  output logic [BANK1_INDEX_WIDTH-1:0]    ext_bank1_out_index,
  input  logic [BANK1_SRC_ADDR_WIDTH-1:0] ext_bank1_src_addr,
  input  logic [BANK1_SRC_SIZE_WIDTH-1:0] ext_bank1_src_size,
  input  logic [BANK1_DST_ADDR_WIDTH-1:0] ext_bank1_des_addr,
  input  logic [BANK1_DST_SIZE_WIDTH-1:0] ext_bank1_des_size,
  input  logic [BANK1_STATUS_WIDTH-1:0]   ext_bank1_status,
  input  logic [BANK1_PROFILE_WIDTH-1:0]  ext_bank1_profile,
  input  logic [BANK0_CONTROL_WIDTH-1:0]  ext_bank0_control,
  input  logic [BANK0_STATUS_WIDTH-1:0]   ext_bank0_status,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_curCnt,
  input  logic [BANK0_CNT_WIDTH-1:0]      ext_bank0_endCnt
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_RESP  = 2'd2
  } state_t;

  state_t                  state_q;
  logic [ADDR_WIDTH-1:0]   read_addr_q;
  logic [DATA_WIDTH-1:0]   rdata_q, rdata_d;
  logic [1:0]              rresp_q, rresp_d;
  logic                    rvalid_q;
  logic                    unused_addr_lsbs;

  assign S_AXI_ARREADY       = (state_q == ST_IDLE) && S_AXI_ARVALID;
  assign S_AXI_RDATA         = rdata_q;
  assign S_AXI_RRESP         = rresp_q;
  assign S_AXI_RVALID        = rvalid_q;
  assign ext_bank1_out_index = read_addr_q[BANK1_INDEX_WIDTH+5:6];
  assign unused_addr_lsbs    = ^read_addr_q[1:0];

  // Row index bits above the index width are simply not decoded, so rows wrap.
  always_comb begin
    rdata_d = '0;
    rresp_d = RESP_SLVERR;
    case (read_addr_q[15:14])
      2'b00: begin
        case (read_addr_q[13:6])
          8'h00: begin rdata_d = DATA_WIDTH'(ext_bank0_control); rresp_d = RESP_OKAY; end
          8'h01: begin rdata_d = DATA_WIDTH'(ext_bank0_status);  rresp_d = RESP_OKAY; end
          8'h02: begin rdata_d = DATA_WIDTH'(ext_bank0_curCnt);  rresp_d = RESP_OKAY; end
          8'h03: begin rdata_d = DATA_WIDTH'(ext_bank0_endCnt);  rresp_d = RESP_OKAY; end
          default: ;
        endcase
      end
      2'b01: begin
        case (read_addr_q[5:2])
          4'd0: begin rdata_d = DATA_WIDTH'(ext_bank1_src_addr); rresp_d = RESP_OKAY; end
          4'd1: begin rdata_d = DATA_WIDTH'(ext_bank1_src_size); rresp_d = RESP_OKAY; end
          4'd2: begin rdata_d = DATA_WIDTH'(ext_bank1_des_addr); rresp_d = RESP_OKAY; end
          4'd3: begin rdata_d = DATA_WIDTH'(ext_bank1_des_size); rresp_d = RESP_OKAY; end
          4'd4: begin rdata_d = DATA_WIDTH'(ext_bank1_status);   rresp_d = RESP_OKAY; end
          4'd5: begin rdata_d = DATA_WIDTH'(ext_bank1_profile);  rresp_d = RESP_OKAY; end
          default: ;
        endcase
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      read_addr_q <= '0;
      rdata_q     <= '0;
      rresp_q     <= RESP_OKAY;
      rvalid_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (S_AXI_ARVALID) begin
            read_addr_q <= S_AXI_ARADDR;
            state_q     <= ST_FETCH;
          end
        end
        // The slot table answers the index one cycle after read_addr settles.
        ST_FETCH: begin
          rdata_q  <= rdata_d;
          rresp_q  <= rresp_d;
          rvalid_q <= 1'b1;
          state_q  <= ST_RESP;
        end
        ST_RESP: begin
          if (S_AXI_RREADY) begin
            rvalid_q <= 1'b0;
            state_q  <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_s_axi_read.sv
// tb/tb_s_axi_read.sv - self-checking bench for s_axi_read
// Directed register-map reads plus randomized reads against a table-driven model.
module tb_s_axi_read;

  logic        clk;
  logic        reset;
  logic [15:0] araddr;
  logic        arvalid;
  logic        arready;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rvalid;
  logic        rready;
  logic [1:0]  out_index;
  logic [31:0] src_addr_w, des_addr_w, profile_w;
  logic [25:0] src_size_w, des_size_w;
  logic [1:0]  status1_w;
  logic [3:0]  control0, status0;
  logic [1:0]  cur_cnt, end_cnt;

  logic [31:0] t_src_addr [4];
  logic [25:0] t_src_size [4];
  logic [31:0] t_des_addr [4];
  logic [25:0] t_des_size [4];
  logic [1:0]  t_status   [4];
  logic [31:0] t_profile  [4];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int last_rv = 0;

  assign src_addr_w = t_src_addr[out_index];
  assign src_size_w = t_src_size[out_index];
  assign des_addr_w = t_des_addr[out_index];
  assign des_size_w = t_des_size[out_index];
  assign status1_w  = t_status[out_index];
  assign profile_w  = t_profile[out_index];

  s_axi_read dut (
    .clk                 (clk),
    .reset               (reset),
    .S_AXI_ARADDR        (araddr),
    .S_AXI_ARVALID       (arvalid),
    .S_AXI_ARREADY       (arready),
    .S_AXI_RDATA         (rdata),
    .S_AXI_RRESP         (rresp),
    .S_AXI_RVALID        (rvalid),
    .S_AXI_RREADY        (rready),
    .ext_bank1_out_index (out_index),
    .ext_bank1_src_addr  (src_addr_w),
    .ext_bank1_src_size  (src_size_w),
    .ext_bank1_des_addr  (des_addr_w),
    .ext_bank1_des_size  (des_size_w),
    .ext_bank1_status    (status1_w),
    .ext_bank1_profile   (profile_w),
    .ext_bank0_control   (control0),
    .ext_bank0_status    (status0),
    .ext_bank0_curCnt    (cur_cnt),
    .ext_bank0_endCnt    (end_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Register map: word offset = addr/4, region = addr/16384, row = (addr/64)%4, field = word%16.
  task automatic model(input logic [15:0] addr, output logic [31:0] d, output logic [1:0] r);
    int region, sel, row, field;
    region = int'(addr) / 16384;
    sel    = (int'(addr) / 64) % 256;
    row    = (int'(addr) / 64) % 4;
    field  = (int'(addr) / 4) % 16;
    d = 32'h0;
    r = 2'b10;
    if (region == 0 && sel < 4) begin
      r = 2'b00;
      if (sel == 0) d = {28'h0, control0};
      else if (sel == 1) d = {28'h0, status0};
      else if (sel == 2) d = {30'h0, cur_cnt};
      else d = {30'h0, end_cnt};
    end else if (region == 1 && field < 6) begin
      r = 2'b00;
      if (field == 0) d = t_src_addr[row];
      else if (field == 1) d = {6'h0, t_src_size[row]};
      else if (field == 2) d = t_des_addr[row];
      else if (field == 3) d = {6'h0, t_des_size[row]};
      else if (field == 4) d = {30'h0, t_status[row]};
      else d = t_profile[row];
    end
  endtask

  task automatic do_read(input logic [15:0] addr, input int hold, input string tag);
    logic [31:0] ed;
    logic [1:0]  er;
    logic [1:0]  row_exp;
    model(addr, ed, er);
    row_exp = addr[7:6];
    @(negedge clk);
    araddr  = addr;
    arvalid = 1'b1;
    rready  = (hold == 0);
    #1;
    check({tag, "_arready"}, 32'(arready), 32'd1);
    @(negedge clk);
    arvalid = 1'b0;
    check({tag, "_fetch_rvalid"}, 32'(rvalid), 32'd0);
    check({tag, "_index"}, 32'(out_index), 32'(row_exp));
    @(negedge clk);
    check({tag, "_rvalid"}, 32'(rvalid), 32'd1);
    check({tag, "_rdata"}, rdata, ed);
    check({tag, "_rresp"}, 32'(rresp), 32'(er));
    last_rv = cyc;
    if (hold > 0) begin
      for (int i = 0; i < hold; i++) begin
        cur_cnt = 2'($urandom);
        araddr  = 16'h0040;
        arvalid = 1'b1;
        #1;
        check({tag, "_hold_arready"}, 32'(arready), 32'd0);
        @(negedge clk);
        check({tag, "_hold_rvalid"}, 32'(rvalid), 32'd1);
        check({tag, "_hold_rdata"}, rdata, ed);
      end
      arvalid = 1'b0;
      rready  = 1'b1;
      @(negedge clk);
      check({tag, "_release_rvalid"}, 32'(rvalid), 32'd0);
      @(negedge clk);
      check({tag, "_no_extra_beat"}, 32'(rvalid), 32'd0);
    end
  endtask

  task automatic randomize_env();
    for (int i = 0; i < 4; i++) begin
      t_src_addr[i] = $urandom;
      t_src_size[i] = 26'($urandom);
      t_des_addr[i] = $urandom;
      t_des_size[i] = 26'($urandom);
      t_status[i]   = 2'($urandom);
      t_profile[i]  = $urandom;
    end
    control0 = 4'($urandom);
    status0  = 4'($urandom);
    cur_cnt  = 2'($urandom);
    end_cnt  = 2'($urandom);
  endtask

  initial begin
    int prev_rv;
    logic [15:0] a;
    reset   = 1'b1;
    araddr  = 16'h0;
    arvalid = 1'b0;
    rready  = 1'b0;
    randomize_env();
    repeat (3) @(negedge clk);
    check("reset_rvalid", 32'(rvalid), 32'd0);
    check("reset_rdata", rdata, 32'd0);
    check("reset_rresp", 32'(rresp), 32'd0);
    check("reset_index", 32'(out_index), 32'd0);
    check("reset_arready", 32'(arready), 32'd0);
    reset = 1'b0;

    end_cnt = 2'b10;
    do_read(16'h00C0, 0, "endcnt");
    check("endcnt_value", rdata, 32'h0000_0002);

    t_src_size[3] = 26'h3FF_FFFF;
    do_read(16'h40C4, 0, "row3_size");
    check("row3_size_value", rdata, 32'h03FF_FFFF);

    do_read(16'h4018, 0, "field6");
    do_read(16'h8000, 0, "region2");
    do_read(16'hC104, 0, "region3");
    do_read(16'h0100, 0, "bank0_sel4");

    do_read(16'h0080, 5, "hold");

    do_read(16'h0000, 0, "b2b_a");
    prev_rv = last_rv;
    do_read(16'h0040, 0, "b2b_b");
    check("b2b_spacing", 32'(last_rv - prev_rv), 32'd3);

    do_read(16'h4F54, 0, "row_wrap");

    for (int n = 0; n < 24; n++) begin
      randomize_env();
      a = 16'($urandom);
      a[15:14] = 2'($urandom_range(0, 3));
      if (a[15:14] == 2'b00) a[13:6] = 8'($urandom_range(0, 5));
      if (a[15:14] == 2'b01) a[5:2] = 4'($urandom_range(0, 7));
      do_read(a, $urandom_range(0, 2), "rand");
    end

    @(negedge clk);
    araddr  = 16'h0040;
    arvalid = 1'b1;
    rready  = 1'b0;
    @(negedge clk);
    arvalid = 1'b0;
    @(negedge clk);
    check("rst_pre_rvalid", 32'(rvalid), 32'd1);
    #2;
    reset = 1'b1;
    #1;
    check("rst_async_rvalid", 32'(rvalid), 32'd0);
    check("rst_async_rdata", rdata, 32'd0);
    check("rst_async_index", 32'(out_index), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    rready = 1'b1;
    @(negedge clk);
    check("rst_no_beat", 32'(rvalid), 32'd0);
    do_read(16'h0000, 0, "after_reset");

    @(negedge clk);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
